// File: rtl/hex_display_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_arbiter_if
// Brief    : Requester-side bundle for the HEX/LEDR display arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface hex_display_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req;
    logic [42*NUM_REQ-1:0] seg_in;
    logic [10*NUM_REQ-1:0] led_in;
    logic [NUM_REQ-1:0]    grant;
    logic [41:0]           hex_seg;
    logic [9:0]            ledr;
    logic [1:0]            owner_id;
    logic                  busy;

    modport master (
        output req, seg_in, led_in,
        input  grant, hex_seg, ledr, owner_id, busy
    );

    modport slave (
        input  req, seg_in, led_in,
        output grant, hex_seg, ledr, owner_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/hex_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_arbiter
// Brief    : Round-robin owner of the HEX/LEDR pins with min-hold and blank gap.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  wire logic              clk,
    input  wire logic              reset,
    hex_display_arbiter_if.slave   bus
);

    localparam logic [41:0]      c_BLANK   = 42'h3FF_FFFF_FFFF;
    localparam logic [CNT_W-1:0] c_HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [1:0]       c_LAST0   = 2'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OWNED  = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t             r_state, w_state_nx;
    logic [NUM_REQ-1:0] r_grant, w_grant_nx;
    logic [41:0]        r_hex, w_hex_nx;
    logic [9:0]         r_led, w_led_nx;
    logic [1:0]         r_owner, w_owner_nx;
    logic               r_busy, w_busy_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [1:0]         r_last, w_last_nx;

    // Slices padded to four entries so a 2-bit index is always in range.
    logic [41:0] w_seg_arr [4];
    logic [9:0]  w_led_arr [4];
    logic [3:0]  w_req_pad;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            if (gi < NUM_REQ) begin : g_used
                assign w_seg_arr[gi] = bus.seg_in[42*gi +: 42];
                assign w_led_arr[gi] = bus.led_in[10*gi +: 10];
                assign w_req_pad[gi] = bus.req[gi];
            end else begin : g_unused
                assign w_seg_arr[gi] = c_BLANK;
                assign w_led_arr[gi] = '0;
                assign w_req_pad[gi] = 1'b0;
            end
        end
    endgenerate

    function automatic logic [1:0] f_rr_idx(input logic [1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[1:0];
    endfunction

    logic       w_found;
    logic [1:0] w_pick;
    logic [3:0] w_pick_oh;
    logic [3:0] w_own_oh;
    logic       w_other;

    // Scan from farthest to nearest so the nearest requester after r_last wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (w_req_pad[f_rr_idx(r_last, i)]) begin
                w_found = 1'b1;
                w_pick  = f_rr_idx(r_last, i);
            end
        end
        w_pick_oh = 4'b0001 << w_pick;
        w_own_oh  = 4'b0001 << r_last;
        w_other   = |(w_req_pad & ~w_own_oh);
    end

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_hex_nx   = c_BLANK;
        w_led_nx   = '0;
        w_owner_nx = r_owner;
        w_busy_nx  = r_busy;
        w_cnt_nx   = r_cnt;
        w_last_nx  = r_last;
        case (r_state)
            S_IDLE, S_SWITCH: begin
                w_grant_nx = '0;
                w_busy_nx  = 1'b0;
                if (w_found) begin
                    w_state_nx = S_OWNED;
                    w_grant_nx = w_pick_oh[NUM_REQ-1:0];
                    w_owner_nx = w_pick;
                    w_busy_nx  = 1'b1;
                    w_cnt_nx   = c_HOLD_M1;
                    w_last_nx  = w_pick;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_OWNED: begin
                // r_last always names the current owner while in S_OWNED.
                if (!w_req_pad[r_last] || (r_cnt == '0 && w_other)) begin
                    w_state_nx = S_SWITCH;
                    w_grant_nx = '0;
                    w_busy_nx  = 1'b0;
                end else begin
                    w_hex_nx = w_seg_arr[r_last];
                    w_led_nx = w_led_arr[r_last];
                    if (r_cnt != '0) w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_grant_nx = '0;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_hex   <= c_BLANK;
            r_led   <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_last  <= c_LAST0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_hex   <= w_hex_nx;
            r_led   <= w_led_nx;
            r_owner <= w_owner_nx;
            r_busy  <= w_busy_nx;
            r_cnt   <= w_cnt_nx;
            r_last  <= w_last_nx;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.hex_seg  = r_hex;
    assign bus.ledr     = r_led;
    assign bus.owner_id = r_owner;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: doc/hex_display_arbiter.md
Name: hex_display_arbiter

Overview:
- Shares the board's six HEX displays (42 active-low segment bits) and ten LEDR outputs between up to four on-chip requesters, such as the HPS debug driver, the snake game engine and the pushbutton splash logic.
- Round-robin arbiter with a minimum-hold timer and a one-cycle blank gap on every hand-off.
- Sits between the requester conduits and the top-level HEX/LEDR pin assignments.

Parameters:
- NUM_REQ, 3: number of requesters, legal range 2..4.
- HOLD_CYCLES, 50000000: minimum ownership time in clk cycles (1 s at 50 MHz); legal range >= 1.
- CNT_W, 26: hold-counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester level request; bit i = requester i.
- seg_in  input  42*NUM_REQ  requester i segment data in [42*i+41:42*i]. Within each slice: [41:35]=HEX0 ... [6:0]=HEX5; active-low.
- led_in  input  10*NUM_REQ  requester i LED data in [10*i+9:10*i]; active-high.
- grant  output  NUM_REQ  one-hot grant, registered.
- hex_seg  output  42  segment bus to HEX0..HEX5, same bit layout as seg_in, registered.
- ledr  output  10  LED bus, registered.
- owner_id  output  2  index of the current owner; valid only while busy=1.
- busy  output  1  high in OWNED state.

Behaviour:
- Reset (synchronous, active-high; takes effect on the next clk edge even mid-ownership):
  - state=IDLE, grant=0, hex_seg=42'h3FF_FFFF_FFFF (all blank), ledr=0, owner_id=0, busy=0.
  - Hold counter cleared.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority after reset.
- Selection rule: scan requesters last+1, last+2, ..., last (modulo NUM_REQ); pick the first with req=1. On each grant, last := the chosen index.
- IDLE:
  - Outputs blank, grant=0.
  - If any req=1 at edge N, then at edge N: state=OWNED, grant[k]=1, owner_id=k, busy=1, counter := HOLD_CYCLES-1.
  - hex_seg/ledr still blank at edge N.
- OWNED, each edge:
  - hex_seg <= seg_in slice k and ledr <= led_in slice k. First owner data therefore appears one cycle after grant rises.
  - Input changes propagate with 1-cycle latency.
  - Counter decrements by 1 and saturates at 0.
- OWNED exits:
  - Owner req[k]=0 sampled -> SWITCH at that edge, regardless of counter value.
  - Counter==0 and any req[j]=1 with j!=k -> SWITCH.
  - Counter==0 and no other request -> remain OWNED indefinitely; counter stays 0.
- SWITCH (exactly one cycle):
  - grant=0, busy=0, hex_seg=all ones, ledr=0.
  - Next edge: apply the selection rule with last=k. The previous owner is re-granted only if it is the sole requester. If no req -> IDLE.
  - Re-grant reloads counter := HOLD_CYCLES-1.
- Simultaneous events:
  - Owner drops req on the same edge the counter reaches 0 -> SWITCH (single path).
  - Multiple new requests -> selection rule only; no fixed priority.
- HOLD_CYCLES=1: counter loads 0, so a competing request forces SWITCH on the first OWNED edge.
- Invariants:
  - grant is one-hot or zero.
  - grant!=0 iff busy=1.
  - hex_seg is never driven from a non-owner slice.
  - The requester data path is purely registered; no combinational path from seg_in to hex_seg.

Test Plan (NUM_REQ=3, HOLD_CYCLES=4 unless noted):
- Reset check: reset=1 for 2 cycles with req=3'b111 -> hex_seg=42'h3FF_FFFF_FFFF, ledr=0, grant=0, busy=0. After release, grant=3'b001 one cycle later, and hex_seg=seg_in[41:0] one cycle after that.
- Single requester hold: req=3'b010 held for 20 cycles with seg_in slice 1=42'h0 -> grant=3'b010 continuously, no SWITCH gap, hex_seg=42'h0 from grant+1 onward, owner_id=1.
- Round-robin rotation: req=3'b111 held -> grant sequence 001,(gap),010,(gap),100,(gap),001. Each owner holds exactly 4 cycles, and each gap is 1 cycle with hex_seg all ones.
- Early release: owner 0 granted, req[0] drops 1 cycle after grant while req[2]=1 -> SWITCH on the next edge (before the counter expires), then grant=3'b100.
- Reset mid-operation: assert reset while owner 2 is at counter=2 -> all outputs at reset values the next edge. After release with req=3'b101, grant=3'b001 (pointer reset, not 3'b100).
- Data latency: while owner 1 holds, toggle led_in slice 1 between 10'h155 and 10'h2AA each cycle -> ledr follows with exactly 1-cycle delay. Changes on slices 0 and 2 never appear on ledr.
